// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: kcpsm6 port-mapped bus master for the RTC multiplexed address/data bus.
// Optional rejected-command counter is built when RTC_CMD_ERR_EN is defined.
module rtc_bus_ctrl #(
   parameter int PHASE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] err_cnt,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] ad_in,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_A_SETUP  = 4'd1,
      S_A_STROBE = 4'd2,
      S_A_HOLD   = 4'd3,
      S_W_SETUP  = 4'd4,
      S_W_STROBE = 4'd5,
      S_W_HOLD   = 4'd6,
      S_R_TURN   = 4'd7,
      S_R_STROBE = 4'd8,
      S_R_HOLD   = 4'd9
   } state_t;

   localparam logic [7:0] PH_LOAD = 8'(PHASE_CYCLES - 1);

   state_t     state_q, state_d, nxt;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       rd_op_q, rd_op_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a_d_q, a_d_d;
   logic       reg_wr_ok;
   logic       cmd_wr;
   logic       cmd_ok;
   logic       start;
   logic       unused_port_bits;

   assign unused_port_bits = ^port_id[7:4];

   // Port decode: address/data/command writes are locked out while a transaction runs.
   always_comb begin
      reg_wr_ok = write_strobe & ~busy_q;
      cmd_wr    = write_strobe & port_id[2];
      cmd_ok    = out_port[0] ^ out_port[1];
      start     = cmd_wr & cmd_ok & ~busy_q;
      addr_d    = (reg_wr_ok & port_id[0]) ? out_port : addr_q;
      data_d    = (reg_wr_ok & port_id[1]) ? out_port : data_q;
      rd_op_d   = start ? out_port[1] : rd_op_q;
   end

   // Phase sequencer: each non-idle state lasts PHASE_CYCLES cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE:     nxt = S_A_SETUP;
         S_A_SETUP:  nxt = S_A_STROBE;
         S_A_STROBE: nxt = S_A_HOLD;
         S_A_HOLD:   nxt = rd_op_q ? S_R_TURN : S_W_SETUP;
         S_W_SETUP:  nxt = S_W_STROBE;
         S_W_STROBE: nxt = S_W_HOLD;
         S_R_TURN:   nxt = S_R_STROBE;
         S_R_STROBE: nxt = S_R_HOLD;
         default:    nxt = S_IDLE;
      endcase
      if (state_q == S_IDLE) begin
         if (start) begin
            state_d = nxt;
            cnt_d   = PH_LOAD;
         end else begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      end else if (cnt_q == 8'd0) begin
         state_d = nxt;
         cnt_d   = PH_LOAD;
         done_d  = (nxt == S_IDLE);
      end else begin
         state_d = state_q;
         cnt_d   = cnt_q - 8'd1;
      end
   end

   // Bus outputs are decoded from the next state so they change on the state edge.
   always_comb begin
      cs_n_d   = 1'b1;
      a_d_d    = 1'b1;
      ad_oe_d  = 1'b0;
      ad_out_d = 8'h00;
      wr_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      case (state_d)
         S_A_SETUP, S_A_HOLD: begin
            cs_n_d = 1'b0; a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = addr_d;
         end
         S_A_STROBE: begin
            cs_n_d = 1'b0; a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = addr_d; wr_n_d = 1'b0;
         end
         S_W_SETUP, S_W_HOLD: begin
            cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = data_d;
         end
         S_W_STROBE: begin
            cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = data_d; wr_n_d = 1'b0;
         end
         S_R_TURN, S_R_HOLD: begin
            cs_n_d = 1'b0;
         end
         S_R_STROBE: begin
            cs_n_d = 1'b0; rd_n_d = 1'b0;
         end
         default: begin
            cs_n_d = 1'b1;
         end
      endcase
      busy_d    = (state_d != S_IDLE);
      rd_data_d = (state_q == S_R_STROBE && cnt_q == 8'd0) ? ad_in : rd_data_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         rd_op_q   <= 1'b0;
         rd_data_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ad_out_q  <= 8'h00;
         ad_oe_q   <= 1'b0;
         cs_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         a_d_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rd_op_q   <= rd_op_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ad_out_q  <= ad_out_d;
         ad_oe_q   <= ad_oe_d;
         cs_n_q    <= cs_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         a_d_q     <= a_d_d;
      end
   end

`ifdef RTC_CMD_ERR_EN
   logic [7:0] err_q, err_d;

   // Rejected command writes count up and saturate; an explicit clear takes priority.
   always_comb begin
      if (write_strobe && port_id[3]) begin
         err_d = 8'h00;
      end else if (cmd_wr && (busy_q || !cmd_ok) && err_q != 8'hFF) begin
         err_d = err_q + 8'h01;
      end else begin
         err_d = err_q;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 8'h00;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

   assign rd_data = rd_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ad_out  = ad_out_q;
   assign ad_oe   = ad_oe_q;
   assign cs_n    = cs_n_q;
   assign rd_n    = rd_n_q;
   assign wr_n    = wr_n_q;
   assign a_d     = a_d_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: one instance with PHASE_CYCLES=4, one with PHASE_CYCLES=1.
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;

`ifdef RTC_CMD_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, write_strobe;
   logic [7:0] port_id, out_port, ad_in;
   logic [7:0] rd_data0, err_cnt0, ad_out0, rd_data1, err_cnt1, ad_out1;
   logic       busy0, done0, ad_oe0, cs_n0, rd_n0, wr_n0, a_d0;
   logic       busy1, done1, ad_oe1, cs_n1, rd_n1, wr_n1, a_d1;
   logic       sel1;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_rd, exp_err;

   rtc_bus_ctrl #(.PHASE_CYCLES(4)) dut0 (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .rd_data(rd_data0), .busy(busy0), .done(done0),
      .err_cnt(err_cnt0), .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in),
      .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .a_d(a_d0)
   );

   rtc_bus_ctrl #(.PHASE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .rd_data(rd_data1), .busy(busy1), .done(done1),
      .err_cnt(err_cnt1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in),
      .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a_d(a_d1)
   );

   logic [7:0] o_rd, o_err, o_ad_out;
   logic       o_busy, o_done, o_ad_oe, o_cs_n, o_rd_n, o_wr_n, o_a_d;
   assign o_rd     = sel1 ? rd_data1 : rd_data0;
   assign o_err    = sel1 ? err_cnt1 : err_cnt0;
   assign o_ad_out = sel1 ? ad_out1  : ad_out0;
   assign o_busy   = sel1 ? busy1    : busy0;
   assign o_done   = sel1 ? done1    : done0;
   assign o_ad_oe  = sel1 ? ad_oe1   : ad_oe0;
   assign o_cs_n   = sel1 ? cs_n1    : cs_n0;
   assign o_rd_n   = sel1 ? rd_n1    : rd_n0;
   assign o_wr_n   = sel1 ? wr_n1    : wr_n0;
   assign o_a_d    = sel1 ? a_d1     : a_d0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'h01;
   endfunction

   // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      write_strobe = 1'b0;
      port_id      = 8'h00;
      out_port     = 8'h00;
      reset        = 1'b0;
   endtask

   task automatic port_wr(input logic [7:0] pid, input logic [7:0] val);
      port_id = pid; out_port = val; write_strobe = 1'b1;
      step();
   endtask

   // Control vector order: busy, done, cs_n, a_d, wr_n, rd_n, ad_oe.
   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, " ctl"}, {o_busy, o_done, o_cs_n, o_a_d, o_wr_n, o_rd_n, o_ad_oe},
          {1'b0, exp_done, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
      chk({tag, " ad_out"}, o_ad_out, 8'h00);
      chk({tag, " rd_data"}, o_rd, exp_rd);
      chk({tag, " err_cnt"}, o_err, ERR_EN ? exp_err : 8'h00);
   endtask

   task automatic bad_cmd(input logic [7:0] v);
      port_wr(8'h04, v);
      exp_err = sat_inc(exp_err);
      chk_idle("bad_cmd", 1'b0);
   endtask

   // Issue a command in the current cycle and check the whole transaction against the
   // phase rules: six phases of p cycles, strobe in the middle phase of each half.
   task automatic txn(input logic [7:0] cpid, input logic [7:0] cval, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] din, input int mid_k, input int rst_k);
      int p, ph;
      bit is_rd;
      logic [6:0] ectl;
      p     = sel1 ? 1 : 4;
      is_rd = cval[1];
      port_id = cpid; out_port = cval; write_strobe = 1'b1;
      step();
      for (int k = 1; k <= 6 * p; k++) begin
         ph = (k - 1) / p;
         ectl = {1'b1, 1'b0, 1'b0, (ph >= 3), !(ph == 1 || (!is_rd && ph == 4)),
                 !(is_rd && ph == 4), (ph < 3 || !is_rd)};
         chk($sformatf("txn c%0d ctl", k),
             {o_busy, o_done, o_cs_n, o_a_d, o_wr_n, o_rd_n, o_ad_oe}, ectl);
         if (ectl[0]) chk($sformatf("txn c%0d ad_out", k), o_ad_out, (ph < 3) ? a : d);
         if (is_rd && k == 5 * p + 1) exp_rd = din;
         chk($sformatf("txn c%0d rd_data", k), o_rd, exp_rd);
         ad_in = (is_rd && ph == 4) ? din : 8'($urandom);
         if (k == mid_k) begin
            port_id = 8'h07; out_port = {6'($urandom), 2'b01}; write_strobe = 1'b1;
            exp_err = sat_inc(exp_err);
         end
         if (k == rst_k) begin
            reset = 1'b1;
            step();
            exp_rd  = 8'h00;
            exp_err = 8'h00;
            chk_idle("post_reset", 1'b0);
            step();
            chk_idle("post_reset+1", 1'b0);
            return;
         end
         step();
      end
      chk_idle("done_cycle", 1'b1);
   endtask

   initial begin
      logic [7:0] a, d, din, v;
      reset = 1'b1; write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
      ad_in = 8'h00; sel1 = 1'b0; exp_rd = 8'h00; exp_err = 8'h00;
      step();
      chk_idle("reset", 1'b0);

      // Directed write then directed read.
      port_wr(8'h01, 8'h21);
      port_wr(8'h02, 8'h59);
      txn(8'h04, 8'h01, 8'h21, 8'h59, 8'h00, 0, 0);
      port_wr(8'h01, 8'h22);
      txn(8'h04, 8'h02, 8'h22, 8'h59, 8'h37, 0, 0);
      step();
      chk_idle("read_hold", 1'b0);

      // Random transactions, including a one-hot multi-register write.
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom); d = 8'($urandom); din = 8'($urandom);
         if (i == 2) begin
            port_wr(8'h03, a);
            d = a;
         end else begin
            port_wr(8'h01, a);
            port_wr(8'h02, d);
         end
         v = {6'($urandom), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01};
         txn(8'h04, v, a, d, din, 0, 0);
      end

      // Commands while busy and invalid patterns are rejected.
      step();
      a = 8'($urandom); d = 8'($urandom);
      port_wr(8'h01, a);
      port_wr(8'h02, d);
      txn(8'h04, 8'h01, a, d, 8'h00, 6, 0);
      step();
      chk_idle("after_mid_cmd", 1'b0);
      bad_cmd(8'h03);
      bad_cmd(8'hF0);
      chk("err_three", o_err, ERR_EN ? 8'd3 : 8'd0);
      port_wr(8'h08, 8'h00);
      exp_err = 8'h00;
      chk_idle("err_clear", 1'b0);

      // Reset during a write, then a read with the cleared address.
      a = 8'($urandom); d = 8'($urandom);
      port_wr(8'h01, a);
      port_wr(8'h02, d);
      txn(8'h04, 8'h01, a, d, 8'h00, 0, 10);
      din = 8'($urandom);
      txn(8'h04, 8'h02, 8'h00, 8'h00, din, 0, 0);

      // Saturation of the error counter, then clear-wins over increment.
      step();
      for (int i = 0; i < 256; i++) begin
         bad_cmd({6'($urandom), ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00});
      end
      chk("err_saturated", o_err, ERR_EN ? 8'hFF : 8'h00);
      port_wr(8'h0C, 8'h00);
      exp_err = 8'h00;
      chk_idle("clear_wins", 1'b0);

      // PHASE_CYCLES=1: read followed by a write issued in the done cycle.
      reset = 1'b1;
      step();
      exp_rd = 8'h00; exp_err = 8'h00; sel1 = 1'b1;
      chk_idle("reset_p1", 1'b0);
      a = 8'($urandom); d = 8'($urandom); din = 8'($urandom);
      port_wr(8'h01, a);
      port_wr(8'h02, d);
      txn(8'h04, 8'h02, a, d, din, 0, 0);
      v = {6'($urandom), 2'b01};
      txn(8'h07, v, v, v, 8'h00, 0, 0);
      txn(8'h04, 8'h02, v, v, 8'($urandom), 0, 0);
      step();
      chk_idle("p1_end", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
